// File: rtl/card_seq_pkg.sv
// Shared types and defaults for the card lock sequencer: FSM state encoding,
// default phase lengths and the phase counter width helper.
package card_seq_pkg;

    localparam int PRESS_CYCLES_DEFAULT   = 4;
    localparam int GAP_CYCLES_DEFAULT     = 4;
    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        PRESS0    = 3'd2,
        GAP0      = 3'd3,
        PRESS1    = 3'd4,
        GAP1      = 3'd5,
        WAIT_READ = 3'd6,
        DONE      = 3'd7
    } seq_state_e;

    // Bits needed to hold the longest phase length without wrapping.
    function automatic int phase_width(input int press, input int gap, input int timeout);
        int longest;
        longest = press;
        if (gap > longest) begin
            longest = gap;
        end
        if (timeout > longest) begin
            longest = timeout;
        end
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// Loadable saturating down-counter; zero flags the last cycle of a phase.
module seq_phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Reload on request, otherwise count down and stick at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/card_lock_sequencer.sv
// Arbitrates two requesters onto a card lock, presses key_0 then key_1,
// then waits for the card read (or a timeout) and reports the result.
module card_lock_sequencer
    import card_seq_pkg::*;
#(
    parameter int PRESS_CYCLES   = PRESS_CYCLES_DEFAULT,
    parameter int GAP_CYCLES     = GAP_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        CLOCK_27,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] code0,
    input  logic [15:0] code1,
    input  logic [1:0]  type0,
    input  logic [1:0]  type1,
    input  logic        card_read,
    input  logic        trip,
    output logic        key_0,
    output logic        key_1,
    output logic [15:0] entry_code,
    output logic [1:0]  card_type,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        result_trip,
    output logic        result_timeout,
    output logic        busy
);

    localparam int PW = phase_width(PRESS_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    // The timer holds (length - 1) so that zero marks the final cycle of a phase.
    localparam logic [PW-1:0] PRESS_LOAD   = PW'(PRESS_CYCLES - 1);
    localparam logic [PW-1:0] GAP_LOAD     = PW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] TIMEOUT_LOAD = PW'(TIMEOUT_CYCLES - 1);

    seq_state_e     state_r;
    seq_state_e     state_next_s;
    logic           last_r;
    logic           winner_s;
    logic           timer_load_s;
    logic [PW-1:0]  timer_value_s;
    logic           timer_zero_s;

    seq_phase_timer #(
        .WIDTH (PW)
    ) u_timer (
        .clk        (CLOCK_27),
        .reset      (reset),
        .load       (timer_load_s),
        .load_value (timer_value_s),
        .zero       (timer_zero_s)
    );

    // Round-robin pick: a lone requester wins, otherwise the one not served last.
    always_comb begin
        winner_s = 1'b0;
        if (req == 2'b11) begin
            winner_s = ~last_r;
        end else begin
            winner_s = req[1];
        end
    end

    // Next-state logic and phase timer reload on every state change.
    always_comb begin
        state_next_s  = state_r;
        timer_value_s = {PW{1'b0}};
        case (state_r)
            IDLE:      state_next_s = (req != 2'b00) ? LOAD : IDLE;
            LOAD:      state_next_s = PRESS0;
            PRESS0:    state_next_s = timer_zero_s ? GAP0 : PRESS0;
            GAP0:      state_next_s = timer_zero_s ? PRESS1 : GAP0;
            PRESS1:    state_next_s = timer_zero_s ? GAP1 : PRESS1;
            GAP1:      state_next_s = timer_zero_s ? WAIT_READ : GAP1;
            WAIT_READ: state_next_s = (card_read || timer_zero_s) ? DONE : WAIT_READ;
            DONE:      state_next_s = IDLE;
            default:   state_next_s = IDLE;
        endcase
        case (state_next_s)
            PRESS0, PRESS1: timer_value_s = PRESS_LOAD;
            GAP0, GAP1:     timer_value_s = GAP_LOAD;
            WAIT_READ:      timer_value_s = TIMEOUT_LOAD;
            default:        timer_value_s = {PW{1'b0}};
        endcase
        timer_load_s = (state_next_s != state_r);
    end

    // State register and registered outputs derived from the next state.
    always_ff @(posedge CLOCK_27 or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            key_0          <= 1'b1;
            key_1          <= 1'b1;
            entry_code     <= 16'h0000;
            card_type      <= 2'b00;
            gnt            <= 2'b00;
            done           <= 2'b00;
            result_trip    <= 1'b0;
            result_timeout <= 1'b0;
            busy           <= 1'b0;
            last_r         <= 1'b1;
        end else begin
            state_r <= state_next_s;
            key_0   <= (state_next_s != PRESS0);
            key_1   <= (state_next_s != PRESS1);
            busy    <= (state_next_s != IDLE);
            done    <= (state_next_s == DONE) ? gnt : 2'b00;
            if (state_r == IDLE && state_next_s == LOAD) begin
                gnt            <= winner_s ? 2'b10 : 2'b01;
                entry_code     <= winner_s ? code1 : code0;
                card_type      <= winner_s ? type1 : type0;
                result_trip    <= 1'b0;
                result_timeout <= 1'b0;
            end else if (state_r == DONE) begin
                gnt    <= 2'b00;
                last_r <= gnt[1];
            end else if (state_r == WAIT_READ && state_next_s == DONE) begin
                // A read on the expiring cycle still counts as a read.
                result_trip    <= card_read & trip;
                result_timeout <= ~card_read;
            end
        end
    end

endmodule

// File: tb/tb_card_lock_sequencer.sv
// Directed bench for card_lock_sequencer with a done-time scoreboard.
module tb_card_lock_sequencer;

    localparam int P = 4;
    localparam int G = 4;
    localparam int T = 8;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [15:0] code;
        logic [1:0]  ctype;
        logic        trip;
        logic        tmo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] code0, code1;
    logic [1:0]  type0, type1;
    logic        card_read, trip;
    logic        key_0, key_1;
    logic [15:0] entry_code;
    logic [1:0]  card_type, gnt, done;
    logic        result_trip, result_timeout, busy;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];
    logic [1:0] prev_done = 2'b00;

    card_lock_sequencer #(
        .PRESS_CYCLES   (P),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLOCK_27       (clk),
        .reset          (reset),
        .req            (req),
        .code0          (code0),
        .code1          (code1),
        .type0          (type0),
        .type1          (type1),
        .card_read      (card_read),
        .trip           (trip),
        .key_0          (key_0),
        .key_1          (key_1),
        .entry_code     (entry_code),
        .card_type      (card_type),
        .gnt            (gnt),
        .done           (done),
        .result_trip    (result_trip),
        .result_timeout (result_timeout),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {key_1, key_0} for sample k after the LOAD sample (k = 0).
    function automatic logic [1:0] exp_keys(input int k);
        if (k >= 1 && k <= P) return 2'b10;
        else if (k >= P + G + 1 && k <= 2 * P + G) return 2'b01;
        else return 2'b11;
    endfunction

    // One clock: sample at the falling edge, run invariants and the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        chk("keys_exclusive", 32'(key_0 | key_1), 32'd1);
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (prev_done != 2'b00) chk("done_single", 32'(done), 32'd0);
        if (done != 2'b00) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_done", 32'(done), 32'(e.gnt));
                chk("sb_gnt", 32'(gnt), 32'(e.gnt));
                chk("sb_code", 32'(entry_code), 32'(e.code));
                chk("sb_type", 32'(card_type), 32'(e.ctype));
                chk("sb_trip", 32'(result_trip), 32'(e.trip));
                chk("sb_timeout", 32'(result_timeout), 32'(e.tmo));
            end
        end
        prev_done = done;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        int c;
        n0 = sb_q.size();
        c = 0;
        while (sb_q.size() == n0 && c < budget) begin
            tick();
            c++;
        end
        chk("done_wait_bound", 32'(sb_q.size() < n0), 32'd1);
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; code0 = 16'h0000; code1 = 16'h0000;
        type0 = 2'b00; type1 = 2'b00; card_read = 1'b0; trip = 1'b0;
        #1;
        chk("rst_keys", 32'({key_1, key_0}), 32'h3);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_code", 32'(entry_code), 32'h0);
        chk("rst_type", 32'(card_type), 32'h0);
        chk("rst_result", 32'({result_trip, result_timeout}), 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Round robin with both requests held; reads complete at once.
        req = 2'b11; code0 = 16'h1111; code1 = 16'h2222; type0 = 2'b01; type1 = 2'b10;
        card_read = 1'b1; trip = 1'b0;
        sb_q.push_back('{2'b01, 16'h1111, 2'b01, 1'b0, 1'b0});
        sb_q.push_back('{2'b10, 16'h2222, 2'b10, 1'b0, 1'b0});
        sb_q.push_back('{2'b01, 16'h1111, 2'b01, 1'b0, 1'b0});
        tick();
        chk("rr_gnt0", 32'(gnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            wait_done(40);
            if (i == 2) req = 2'b00;
            tick();
            chk("rr_idle_gnt", 32'(gnt), 32'h0);
            chk("rr_idle_busy", 32'(busy), 32'h0);
            if (i < 2) begin
                tick();
                chk("rr_next_gnt", 32'(gnt), (i == 0) ? 32'h2 : 32'h1);
            end
        end
        card_read = 1'b0;
        tick();

        // Basic transaction: read with trip four cycles into WAIT_READ.
        req = 2'b01; code0 = 16'hCABB; type0 = 2'b10;
        sb_q.push_back('{2'b01, 16'hCABB, 2'b10, 1'b1, 1'b0});
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_code_load", 32'(entry_code), 32'hCABB);
        chk("t1_type_load", 32'(card_type), 32'h2);
        chk("t1_keys_load", 32'({key_1, key_0}), 32'h3);
        req = 2'b00; code0 = 16'h0000; type0 = 2'b00;
        for (int k = 1; k <= 2 * P + 2 * G + 4; k++) begin
            tick();
            chk("t1_keys", 32'({key_1, key_0}), 32'(exp_keys(k)));
            chk("t1_code", 32'(entry_code), 32'hCABB);
            chk("t1_busy", 32'(busy), 32'h1);
            chk("t1_no_done", 32'(done), 32'h0);
        end
        card_read = 1'b1; trip = 1'b1;
        tick();
        chk("t1_done", 32'(done), 32'h1);
        card_read = 1'b0; trip = 1'b0;

        // Timeout: card_read never arrives, trip ignored.
        tick();
        tick();
        req = 2'b01; code0 = 16'h1234; type0 = 2'b01; trip = 1'b1;
        sb_q.push_back('{2'b01, 16'h1234, 2'b01, 1'b0, 1'b1});
        tick();
        req = 2'b00;
        for (int k = 1; k <= 2 * P + 2 * G + T + 1; k++) begin
            tick();
            chk("to_keys", 32'({key_1, key_0}), 32'(exp_keys(k)));
            chk("to_done", 32'(done), (k == 2 * P + 2 * G + T + 1) ? 32'h1 : 32'h0);
        end
        trip = 1'b0;

        // Reset in PRESS1 with requester 1 pending.
        tick();
        tick();
        req = 2'b01; code0 = 16'h4444; type0 = 2'b00; code1 = 16'h7777; type1 = 2'b11;
        tick();
        req = 2'b00;
        for (int k = 1; k <= P + G + 2; k++) tick();
        chk("rs_key1_low", 32'(key_1), 32'h0);
        req = 2'b10;
        #1 reset = 1'b1;
        #1;
        chk("rs_keys_async", 32'({key_1, key_0}), 32'h3);
        chk("rs_gnt_async", 32'(gnt), 32'h0);
        chk("rs_busy_async", 32'(busy), 32'h0);
        tick();
        tick();
        chk("rs_no_done", 32'(done), 32'h0);
        reset = 1'b0; card_read = 1'b1; trip = 1'b1;
        sb_q.push_back('{2'b10, 16'h7777, 2'b11, 1'b1, 1'b0});
        tick();
        chk("rs_first_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        wait_done(40);
        card_read = 1'b0; trip = 1'b0;

        // req dropped in GAP0; stray card_read in the next PRESS0 is ignored.
        tick();
        tick();
        req = 2'b01; code0 = 16'hABCD; type0 = 2'b10;
        sb_q.push_back('{2'b01, 16'hABCD, 2'b10, 1'b0, 1'b0});
        tick();
        for (int k = 1; k <= P + 1; k++) tick();
        req = 2'b00; code0 = 16'hFFFF; type0 = 2'b11;
        for (int k = P + 2; k <= 2 * P + 2 * G + 1; k++) tick();
        card_read = 1'b1;
        wait_done(10);
        card_read = 1'b0;
        tick();
        req = 2'b10; code1 = 16'h5555; type1 = 2'b11;
        sb_q.push_back('{2'b10, 16'h5555, 2'b11, 1'b0, 1'b1});
        tick();
        req = 2'b00;
        tick();
        chk("stray_in_press0", 32'(key_0), 32'h0);
        card_read = 1'b1; trip = 1'b1;
        tick();
        card_read = 1'b0; trip = 1'b0;
        wait_done(40);

        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
